// File: rtl/stopwatch_ctrl.sv
// Stopwatch key-handling controller: IDLE / RUN / PAUSE / HIST state machine
// with lap-record write pointer, history read pointer and record count.
// All outputs are registered and follow the edge that samples a key pulse.
// Optional build macro HIST_WRAP_EN: history reads wrap from the last record
// back to record 0 instead of holding on the last record.
module stopwatch_ctrl #(
   parameter int DEPTH = 16
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       mode_stopwatch,
   input  logic       sta_sto_his_flag,
   input  logic       clr_flag,
   input  logic       store_flag,
   input  logic       read_flag,
   output logic       count_en,
   output logic       clr_cnt,
   output logic       wr_en,
   output logic [4:0] wr_addr,
   output logic [4:0] rd_addr,
   output logic       disp_mode,
   output logic       full_indicator,
   output logic [4:0] num_order
);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, HIST} state_t;

   localparam logic [4:0] DEPTH_C = 5'(DEPTH);

   state_t     state_q, state_d;
   state_t     ret_q, ret_d;
   logic [4:0] wr_ptr_q, wr_ptr_d;
   logic [4:0] rd_ptr_q, rd_ptr_d;
   logic [4:0] rec_cnt_q, rec_cnt_d;
   logic       count_en_q, count_en_d;
   logic       clr_cnt_q, clr_cnt_d;
   logic       wr_en_q, wr_en_d;
   logic [4:0] wr_addr_q, wr_addr_d;
   logic       disp_mode_q, disp_mode_d;
   logic       full_q, full_d;
   logic [4:0] num_order_q, num_order_d;

   // Only the highest-priority pulse present is considered; all keys are
   // masked while the stopwatch mode is not selected.
   logic k_clr, k_sta, k_store, k_read;
   assign k_clr   = mode_stopwatch & clr_flag;
   assign k_sta   = mode_stopwatch & sta_sto_his_flag & ~clr_flag;
   assign k_store = mode_stopwatch & store_flag & ~clr_flag & ~sta_sto_his_flag;
   assign k_read  = mode_stopwatch & read_flag & ~clr_flag & ~sta_sto_his_flag
                    & ~store_flag;

   // Next-state, pointer and registered-output computation.
   always_comb begin
      state_d   = state_q;
      ret_d     = ret_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      rec_cnt_d = rec_cnt_q;
      wr_addr_d = wr_addr_q;
      wr_en_d   = 1'b0;
      clr_cnt_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (k_sta) begin
               state_d = RUN;
            end else if (k_read && rec_cnt_q != 5'd0) begin
               state_d  = HIST;
               ret_d    = IDLE;
               rd_ptr_d = 5'd0;
            end
         end
         RUN: begin
            if (k_sta) begin
               state_d = PAUSE;
            end else if (k_store && rec_cnt_q < DEPTH_C) begin
               wr_en_d   = 1'b1;
               wr_addr_d = wr_ptr_q;
               wr_ptr_d  = wr_ptr_q + 5'd1;
               rec_cnt_d = rec_cnt_q + 5'd1;
            end
         end
         PAUSE: begin
            if (k_clr) begin
               state_d   = IDLE;
               clr_cnt_d = 1'b1;
               wr_ptr_d  = 5'd0;
               rd_ptr_d  = 5'd0;
               rec_cnt_d = 5'd0;
            end else if (k_sta) begin
               state_d = RUN;
            end else if (k_read && rec_cnt_q != 5'd0) begin
               state_d  = HIST;
               ret_d    = PAUSE;
               rd_ptr_d = 5'd0;
            end
         end
         HIST: begin
            if (k_clr) begin
               state_d   = IDLE;
               clr_cnt_d = 1'b1;
               wr_ptr_d  = 5'd0;
               rd_ptr_d  = 5'd0;
               rec_cnt_d = 5'd0;
            end else if (k_sta) begin
               state_d = ret_q;
            end else if (k_read) begin
               if (rd_ptr_q == rec_cnt_q - 5'd1) begin
`ifdef HIST_WRAP_EN
                  rd_ptr_d = 5'd0;
`else
                  rd_ptr_d = rd_ptr_q;
`endif
               end else begin
                  rd_ptr_d = rd_ptr_q + 5'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      count_en_d  = (state_d == RUN);
      disp_mode_d = (state_d == HIST);
      full_d      = (rec_cnt_d == DEPTH_C);
      num_order_d = (state_d == HIST) ? rd_ptr_d + 5'd1 : rec_cnt_d;
   end

   // State, pointer and output registers with synchronous active-low reset.
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ret_q       <= IDLE;
         wr_ptr_q    <= 5'd0;
         rd_ptr_q    <= 5'd0;
         rec_cnt_q   <= 5'd0;
         count_en_q  <= 1'b0;
         clr_cnt_q   <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= 5'd0;
         disp_mode_q <= 1'b0;
         full_q      <= 1'b0;
         num_order_q <= 5'd0;
      end else begin
         state_q     <= state_d;
         ret_q       <= ret_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         rec_cnt_q   <= rec_cnt_d;
         count_en_q  <= count_en_d;
         clr_cnt_q   <= clr_cnt_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         disp_mode_q <= disp_mode_d;
         full_q      <= full_d;
         num_order_q <= num_order_d;
      end
   end

   assign count_en       = count_en_q;
   assign clr_cnt        = clr_cnt_q;
   assign wr_en          = wr_en_q;
   assign wr_addr        = wr_addr_q;
   assign rd_addr        = rd_ptr_q;
   assign disp_mode      = disp_mode_q;
   assign full_indicator = full_q;
   assign num_order      = num_order_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed-vector bench for stopwatch_ctrl (DEPTH = 4).
module tb_stopwatch_ctrl;

   logic       sys_clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       mode_stopwatch = 1'b0;
   logic       sta_sto_his_flag = 1'b0;
   logic       clr_flag = 1'b0;
   logic       store_flag = 1'b0;
   logic       read_flag = 1'b0;
   logic       count_en, clr_cnt, wr_en, disp_mode, full_indicator;
   logic [4:0] wr_addr, rd_addr, num_order;

   stopwatch_ctrl #(.DEPTH(4)) dut (
      .sys_clk(sys_clk), .rst_n(rst_n), .mode_stopwatch(mode_stopwatch),
      .sta_sto_his_flag(sta_sto_his_flag), .clr_flag(clr_flag),
      .store_flag(store_flag), .read_flag(read_flag),
      .count_en(count_en), .clr_cnt(clr_cnt), .wr_en(wr_en),
      .wr_addr(wr_addr), .rd_addr(rd_addr), .disp_mode(disp_mode),
      .full_indicator(full_indicator), .num_order(num_order)
   );

   always #5 sys_clk = ~sys_clk;

`ifdef HIST_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif
   // Fourth read of three records: back to record 0, or held on record 2.
   localparam logic [4:0] RA4 = WRAP ? 5'd0 : 5'd2;
   localparam logic [4:0] NO4 = WRAP ? 5'd1 : 5'd3;

   // inputs: rst_n mode sta clr store read
   // expected outputs: ce cc we wa ra dm full no
   typedef struct packed {
      logic [5:0]  in;
      logic [19:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   applied = 0;
   int   miscompares = 0;

   function automatic vec_t v(input logic r, m, s, c, st, rd,
                              input logic ce, cc, we, input logic [4:0] wa, ra,
                              input logic dm, fu, input logic [4:0] no);
      vec_t t;
      t.in  = {r, m, s, c, st, rd};
      t.exp = {ce, cc, we, wa, ra, dm, fu, no};
      return t;
   endfunction

   function automatic logic [19:0] outs();
      return {count_en, clr_cnt, wr_en, wr_addr, rd_addr, disp_mode,
              full_indicator, num_order};
   endfunction

   task automatic drive(input logic [5:0] in);
      @(negedge sys_clk);
      {rst_n, mode_stopwatch, sta_sto_his_flag, clr_flag, store_flag, read_flag} = in;
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string name, input logic [19:0] act, input logic [19:0] req);
      applied++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: actual {ce,cc,we,wa,ra,dm,full,no}=%05h required=%05h",
                  name, act, req);
      end
   endtask

   initial begin
      //            r m s c st rd  ce cc we wa    ra    dm fu no
      vecs.push_back(v(0,0,0,0,0,0, 0,0,0,5'd0,5'd0,0,0,5'd0)); // reset
      vecs.push_back(v(1,1,0,0,0,0, 0,0,0,5'd0,5'd0,0,0,5'd0)); // idle
      vecs.push_back(v(1,1,0,0,1,0, 0,0,0,5'd0,5'd0,0,0,5'd0)); // idle store ignored
      vecs.push_back(v(1,1,0,1,0,0, 0,0,0,5'd0,5'd0,0,0,5'd0)); // idle clr ignored
      vecs.push_back(v(1,1,0,0,0,1, 0,0,0,5'd0,5'd0,0,0,5'd0)); // read, no records
      vecs.push_back(v(1,1,1,0,0,0, 1,0,0,5'd0,5'd0,0,0,5'd0)); // -> RUN
      vecs.push_back(v(1,1,0,0,1,0, 1,0,1,5'd0,5'd0,0,0,5'd1)); // store 0
      vecs.push_back(v(1,1,0,0,0,0, 1,0,0,5'd0,5'd0,0,0,5'd1));
      vecs.push_back(v(1,1,0,0,1,0, 1,0,1,5'd1,5'd0,0,0,5'd2)); // store 1
      vecs.push_back(v(1,1,0,0,1,1, 1,0,1,5'd2,5'd0,0,0,5'd3)); // store 2 beats read
      vecs.push_back(v(1,1,0,0,0,1, 1,0,0,5'd2,5'd0,0,0,5'd3)); // RUN read ignored
      vecs.push_back(v(1,1,0,1,0,0, 1,0,0,5'd2,5'd0,0,0,5'd3)); // RUN clr ignored
      vecs.push_back(v(1,1,1,0,0,0, 0,0,0,5'd2,5'd0,0,0,5'd3)); // -> PAUSE
      vecs.push_back(v(1,1,0,0,0,1, 0,0,0,5'd2,5'd0,1,0,5'd1)); // -> HIST rd 0
      vecs.push_back(v(1,1,0,0,0,1, 0,0,0,5'd2,5'd1,1,0,5'd2)); // rd 1
      vecs.push_back(v(1,1,0,0,0,1, 0,0,0,5'd2,5'd2,1,0,5'd3)); // rd 2
      vecs.push_back(v(1,1,0,0,0,1, 0,0,0,5'd2,RA4, 1,0,NO4 )); // last-record read
      vecs.push_back(v(1,1,0,0,1,0, 0,0,0,5'd2,RA4, 1,0,NO4 )); // HIST store ignored
      vecs.push_back(v(1,1,1,0,0,0, 0,0,0,5'd2,RA4, 0,0,5'd3)); // back to PAUSE
      vecs.push_back(v(1,1,1,0,0,1, 1,0,0,5'd2,RA4, 0,0,5'd3)); // sta beats read -> RUN
      vecs.push_back(v(1,1,0,0,1,0, 1,0,1,5'd3,RA4, 0,1,5'd4)); // store 3, full
      vecs.push_back(v(1,1,0,0,1,0, 1,0,0,5'd3,RA4, 0,1,5'd4)); // full store ignored
      vecs.push_back(v(1,0,1,0,0,0, 1,0,0,5'd3,RA4, 0,1,5'd4)); // mode off: sta
      vecs.push_back(v(1,0,0,1,0,0, 1,0,0,5'd3,RA4, 0,1,5'd4)); // mode off: clr
      vecs.push_back(v(1,0,0,0,1,0, 1,0,0,5'd3,RA4, 0,1,5'd4)); // mode off: store
      vecs.push_back(v(1,1,1,0,0,0, 0,0,0,5'd3,RA4, 0,1,5'd4)); // mode on: -> PAUSE
      vecs.push_back(v(1,1,1,1,1,0, 0,1,0,5'd3,5'd0,0,0,5'd0)); // clr+sta+store
      vecs.push_back(v(1,1,0,0,0,0, 0,0,0,5'd3,5'd0,0,0,5'd0)); // IDLE
      vecs.push_back(v(1,1,1,0,0,0, 1,0,0,5'd3,5'd0,0,0,5'd0)); // -> RUN
      vecs.push_back(v(1,1,0,0,1,0, 1,0,1,5'd0,5'd0,0,0,5'd1)); // store restarts at 0
      vecs.push_back(v(1,1,1,0,0,0, 0,0,0,5'd0,5'd0,0,0,5'd1)); // -> PAUSE
      vecs.push_back(v(1,1,0,0,0,1, 0,0,0,5'd0,5'd0,1,0,5'd1)); // -> HIST
      vecs.push_back(v(1,1,0,0,0,1, 0,0,0,5'd0,5'd0,1,0,5'd1)); // single-record read
      vecs.push_back(v(1,1,0,1,0,0, 0,1,0,5'd0,5'd0,0,0,5'd0)); // HIST clr -> IDLE
      vecs.push_back(v(1,1,0,0,0,0, 0,0,0,5'd0,5'd0,0,0,5'd0));
      vecs.push_back(v(1,1,1,0,0,0, 1,0,0,5'd0,5'd0,0,0,5'd0)); // -> RUN
      vecs.push_back(v(1,1,0,0,1,0, 1,0,1,5'd0,5'd0,0,0,5'd1)); // wr_en cycle
      vecs.push_back(v(0,1,0,0,1,0, 0,0,0,5'd0,5'd0,0,0,5'd0)); // reset during wr_en
      vecs.push_back(v(1,0,1,0,0,0, 0,0,0,5'd0,5'd0,0,0,5'd0)); // mode off in IDLE

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].in);
         check($sformatf("vec%0d", i), outs(), vecs[i].exp);
      end

      // Back-to-back stores from reset: strobe for slots 0..3, then full and held.
      drive(6'b000000);
      drive(6'b111000);
      check("seq_run", outs(), {1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0});
      for (int k = 0; k < 6; k++) begin
         logic [4:0] n;
         drive(6'b110010);
         n = (k < 4) ? 5'(k + 1) : 5'd4;
         check($sformatf("seq_store%0d", k), outs(),
               {1'b1, 1'b0, (k < 4), (k < 4) ? 5'(k) : 5'd3, 5'd0, 1'b0,
                (k >= 3), n});
      end
      // Strobe must drop for the idle cycle that follows.
      drive(6'b110000);
      check("seq_quiet", outs(), {1'b1, 1'b0, 1'b0, 5'd3, 5'd0, 1'b0, 1'b1, 5'd4});

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: actual=running required=finished");
      $fatal(1);
   end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter DEPTH, default 16, number of lap-record slots (legal range 1..31).
REQ-002 sys_clk  input  1  single system clock; all logic on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on sys_clk rising edge.
REQ-004 mode_stopwatch  input  1  high = stopwatch mode; key pulses honoured only when high.
REQ-005 sta_sto_his_flag  input  1  start/stop/exit-history key, one-cycle pulse.
REQ-006 clr_flag  input  1  clear key, one-cycle pulse.
REQ-007 store_flag  input  1  lap-store key, one-cycle pulse.
REQ-008 read_flag  input  1  history-read/next key, one-cycle pulse.
REQ-009 count_en  output  1  counter enable, high only in RUN.
REQ-010 clr_cnt  output  1  one-cycle counter/record clear pulse.
REQ-011 wr_en  output  1  one-cycle lap-record write strobe.
REQ-012 wr_addr  output  5  record slot for the write strobe.
REQ-013 rd_addr  output  5  record slot being displayed.
REQ-014 disp_mode  output  1  1 = display stored record, 0 = live time.
REQ-015 full_indicator  output  1  high when record count equals DEPTH.
REQ-016 num_order  output  5  displayed record number.

Function
REQ-017 The block SHALL implement states IDLE, RUN, PAUSE and HIST; all outputs SHALL be registered, changing on the edge after the triggering pulse cycle.
REQ-018 When mode_stopwatch is low, all key pulses SHALL be ignored and state, pointers and outputs held, so a running counter keeps running.
REQ-019 Simultaneous pulses SHALL be resolved by priority clr > sta_sto_his > store > read; only the highest-priority pulse acts.
REQ-020 IDLE: sta -> RUN; read with rec_cnt>0 -> HIST (return state IDLE); store and clr ignored.
REQ-021 RUN: sta -> PAUSE; store with rec_cnt<DEPTH SHALL assert wr_en one cycle with wr_addr=wr_ptr, then increment wr_ptr and rec_cnt; store when full is ignored; clr and read ignored.
REQ-022 PAUSE: sta -> RUN; clr -> IDLE; read with rec_cnt>0 -> HIST (return state PAUSE); store ignored.
REQ-023 Any accepted clr (PAUSE or HIST) SHALL pulse clr_cnt one cycle and zero wr_ptr, rd_ptr and rec_cnt.
REQ-024 Entry to HIST SHALL set rd_ptr=0; each further read SHALL increment rd_ptr; read at rd_ptr=rec_cnt-1 per REQ-032/033.
REQ-025 HIST: sta SHALL return to the saved state (IDLE or PAUSE) without changing counters; clr -> IDLE per REQ-023; store ignored.
REQ-026 count_en=1 iff state is RUN; disp_mode=1 iff state is HIST.
REQ-027 rd_addr=rd_ptr; num_order=rd_ptr+1 in HIST, else rec_cnt.
REQ-028 full_indicator=1 iff rec_cnt==DEPTH; rec_cnt and wr_ptr SHALL never exceed DEPTH.

Reset
REQ-029 With rst_n low at a clock edge: state=IDLE, wr_ptr=rd_ptr=rec_cnt=0, count_en=0, clr_cnt=0, wr_en=0, wr_addr=0, rd_addr=0, disp_mode=0, full_indicator=0, num_order=0.
REQ-030 Reset asserted mid-operation (including the wr_en cycle) SHALL take priority over all key pulses and complete in one edge.
REQ-031 No output SHALL change asynchronously to sys_clk.

Configuration
REQ-032 With macro HIST_WRAP_EN defined, read at rd_ptr=rec_cnt-1 SHALL wrap rd_ptr to 0.
REQ-033 Without HIST_WRAP_EN, read at rd_ptr=rec_cnt-1 SHALL hold rd_ptr (saturate); all other behaviour identical.

Verification
REQ-034 Reset, sta pulse, 3 store pulses -> count_en=1, wr_en strobes at wr_addr 0,1,2, num_order=3, full_indicator=0.
REQ-035 DEPTH=4, RUN, 5 store pulses -> 4 wr_en strobes (addr 0..3), 5th ignored, full_indicator=1, num_order=4.
REQ-036 PAUSE with 3 records, read x4 -> rd_addr 0,1,2 then 0 (HIST_WRAP_EN) or 2 (not defined); num_order tracks rd_ptr+1; disp_mode=1; sta -> PAUSE, disp_mode=0.
REQ-037 PAUSE, clr+sta+store in same cycle -> clr_cnt pulse, state IDLE, rec_cnt=0, count_en=0, no wr_en.
REQ-038 RUN, mode_stopwatch=0, sta/clr/store pulses -> count_en stays 1, no wr_en/clr_cnt; mode_stopwatch=1, sta -> PAUSE.
REQ-039 rst_n low during wr_en cycle in RUN -> next edge all outputs at REQ-029 values.
